// File: rtl/mem_bus_arbiter.sv
// Two-master to one-slave memory bus arbiter: fetch (ibus) and memory-stage (dbus) share cbus.
// dbus has priority, bounded by MAX_DWIN consecutive wins while ibus is waiting.
package mem_bus_pkg;
  typedef logic [2:0] msize_t;
  typedef logic [7:0] mlen_t;
  typedef logic [1:0] axi_burst_t;

  localparam msize_t     MSIZE1          = 3'd0;
  localparam msize_t     MSIZE2          = 3'd1;
  localparam msize_t     MSIZE4          = 3'd2;
  localparam msize_t     MSIZE8          = 3'd3;
  localparam mlen_t      MLEN1           = 8'd0;
  localparam axi_burst_t AXI_BURST_FIXED = 2'd0;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    mlen_t       len;
    axi_burst_t  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

// state   | meaning
// IDLE    | bus free, arbitrate this cycle
// GRANT_I | latched fetch request owns the bus
// GRANT_D | latched memory-stage request owns the bus
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned MAX_DWIN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT_I = 2'd1;
  localparam logic [1:0] GRANT_D = 2'd2;

  localparam logic [3:0] DWIN_LIMIT = 4'(MAX_DWIN);

  logic [1:0] state;
  logic [3:0] dwinCnt;
  cbus_req_t  reqQ;

  logic dwinHit;
  logic grantI;
  logic grantD;
  logic busy;
  logic done;

  assign dwinHit = (dwinCnt == DWIN_LIMIT);
  assign grantI  = (state == IDLE) && ireq.valid && (!dreq.valid || dwinHit);
  assign grantD  = (state == IDLE) && dreq.valid && !(ireq.valid && dwinHit);
  assign busy    = (state == GRANT_I) || (state == GRANT_D);
  assign done    = busy && oresp.ready && oresp.last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      dwinCnt <= '0;
      reqQ    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grantI) begin
            state   <= GRANT_I;
            dwinCnt <= '0;
            reqQ    <= '{valid: 1'b0, is_write: 1'b0, size: MSIZE4, addr: ireq.addr,
                         strobe: 8'h00, data: 64'h0, len: MLEN1, burst: AXI_BURST_FIXED};
          end else if (grantD) begin
            state   <= GRANT_D;
            // the counter only tracks dbus wins taken at ibus's expense
            dwinCnt <= ireq.valid ? dwinCnt + 4'd1 : 4'd0;
            reqQ    <= '{valid: 1'b0, is_write: |dreq.strobe, size: dreq.size, addr: dreq.addr,
                         strobe: dreq.strobe, data: dreq.data, len: MLEN1, burst: AXI_BURST_FIXED};
          end
        end
        GRANT_I, GRANT_D: begin
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    oreq       = reqQ;
    oreq.valid = busy;
  end

  always_comb begin
    iresp.addr_ok = done && (state == GRANT_I);
    iresp.data_ok = done && (state == GRANT_I);
    iresp.data    = reqQ.addr[2] ? oresp.data[63:32] : oresp.data[31:0];
    dresp.addr_ok = done && (state == GRANT_D);
    dresp.data_ok = done && (state == GRANT_D);
    dresp.data    = oresp.data;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: lone fetch/store, multi-beat, contention, drop, reset.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  logic       clk;
  logic       reset;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  int checkCnt = 0;
  int errCnt   = 0;

  mem_bus_arbiter #(.MAX_DWIN(4)) dut (
    .clk  (clk),
    .reset(reset),
    .ireq (ireq),
    .iresp(iresp),
    .dreq (dreq),
    .dresp(dresp),
    .oreq (oreq),
    .oresp(oresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] BUS_DATA = 64'h1122_3344_5566_7788;

  logic expD [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    reset = 1'b1;
    ireq  = '0;
    dreq  = '0;
    oresp = '0;
    #3;
    chk("rst_oreq_valid", 64'(oreq.valid), 64'd0);
    chk("rst_i_data_ok", 64'(iresp.data_ok), 64'd0);
    chk("rst_d_data_ok", 64'(dresp.data_ok), 64'd0);
    chk("rst_d_addr_ok", 64'(dresp.addr_ok), 64'd0);
    step();
    step();
    reset = 1'b0;

    // lone fetch, upper word selected by addr[2]
    ireq.valid = 1'b1;
    ireq.addr  = 64'h8000_0004;
    #1 chk("fetch_T_valid", 64'(oreq.valid), 64'd0);
    step();
    chk("fetch_T1_valid", 64'(oreq.valid), 64'd1);
    chk("fetch_is_write", 64'(oreq.is_write), 64'd0);
    chk("fetch_addr", oreq.addr, 64'h8000_0004);
    chk("fetch_size", 64'(oreq.size), 64'(MSIZE4));
    chk("fetch_strobe", 64'(oreq.strobe), 64'd0);
    chk("fetch_T1_data_ok", 64'(iresp.data_ok), 64'd0);
    step();
    chk("fetch_T2_valid", 64'(oreq.valid), 64'd1);
    chk("fetch_T2_data_ok", 64'(iresp.data_ok), 64'd0);
    step();
    oresp = '{ready: 1'b1, last: 1'b1, data: BUS_DATA};
    #1;
    chk("fetch_T3_valid", 64'(oreq.valid), 64'd1);
    chk("fetch_T3_data_ok", 64'(iresp.data_ok), 64'd1);
    chk("fetch_T3_addr_ok", 64'(iresp.addr_ok), 64'd1);
    chk("fetch_data", 64'(iresp.data), 64'h1122_3344);
    chk("fetch_d_data_ok", 64'(dresp.data_ok), 64'd0);
    step();
    ireq.valid = 1'b0;
    oresp      = '0;
    #1;
    chk("fetch_idle_valid", 64'(oreq.valid), 64'd0);
    chk("fetch_idle_data_ok", 64'(iresp.data_ok), 64'd0);

    // lone store
    dreq = '{valid: 1'b1, addr: 64'h100, size: MSIZE4, strobe: 8'h0F, data: 64'hAB};
    step();
    chk("store_valid", 64'(oreq.valid), 64'd1);
    chk("store_is_write", 64'(oreq.is_write), 64'd1);
    chk("store_strobe", 64'(oreq.strobe), 64'h0F);
    chk("store_data", oreq.data, 64'hAB);
    chk("store_addr", oreq.addr, 64'h100);
    chk("store_len", 64'(oreq.len), 64'(MLEN1));
    chk("store_burst", 64'(oreq.burst), 64'(AXI_BURST_FIXED));
    chk("store_early_data_ok", 64'(dresp.data_ok), 64'd0);
    step();
    oresp = '{ready: 1'b1, last: 1'b1, data: 64'hDEAD_BEEF_0000_0001};
    #1;
    chk("store_data_ok", 64'(dresp.data_ok), 64'd1);
    chk("store_addr_ok", 64'(dresp.addr_ok), 64'd1);
    chk("store_resp_data", dresp.data, 64'hDEAD_BEEF_0000_0001);
    chk("store_i_data_ok", 64'(iresp.data_ok), 64'd0);
    step();
    dreq.valid = 1'b0;
    oresp      = '0;

    // multi-beat: ready without last must not complete
    dreq.valid = 1'b1;
    step();
    oresp = '{ready: 1'b1, last: 1'b0, data: 64'h5};
    #1 chk("beat1_data_ok", 64'(dresp.data_ok), 64'd0);
    step();
    chk("beat2_valid", 64'(oreq.valid), 64'd1);
    chk("beat2_data_ok", 64'(dresp.data_ok), 64'd0);
    step();
    oresp.last = 1'b1;
    #1;
    chk("beat3_valid", 64'(oreq.valid), 64'd1);
    chk("beat3_data_ok", 64'(dresp.data_ok), 64'd1);
    step();
    dreq.valid = 1'b0;
    oresp      = '0;

    // contention, one-cycle transactions
    ireq  = '{valid: 1'b1, addr: 64'h1000};
    dreq.valid = 1'b1;
    oresp = '{ready: 1'b1, last: 1'b1, data: BUS_DATA};
    for (int k = 0; k < 10; k++) begin
      #1 chk($sformatf("cont%0d_idle", k), 64'(oreq.valid), 64'd0);
      step();
      chk($sformatf("cont%0d_d_ok", k), 64'(dresp.data_ok), 64'(expD[k]));
      chk($sformatf("cont%0d_i_ok", k), 64'(iresp.data_ok), 64'(!expD[k]));
      if (!expD[k]) chk($sformatf("cont%0d_i_data", k), 64'(iresp.data), 64'h5566_7788);
      step();
    end
    ireq.valid = 1'b0;
    dreq.valid = 1'b0;
    oresp      = '0;

    // requester drop mid-transaction
    dreq = '{valid: 1'b1, addr: 64'h200, size: MSIZE8, strobe: 8'hFF, data: 64'hAB};
    step();
    dreq.valid = 1'b0;
    dreq.data  = 64'h0;
    #1;
    chk("drop_valid", 64'(oreq.valid), 64'd1);
    chk("drop_latched_data", oreq.data, 64'hAB);
    step();
    chk("drop_still_granted", 64'(oreq.valid), 64'd1);
    oresp = '{ready: 1'b1, last: 1'b1, data: 64'h0};
    step();
    oresp = '0;
    #1 chk("drop_idle", 64'(oreq.valid), 64'd0);
    step();
    chk("drop_no_spurious", 64'(oreq.valid), 64'd0);

    // reset in the middle of a fetch
    ireq = '{valid: 1'b1, addr: 64'h8000_0000};
    step();
    chk("rstmid_granted", 64'(oreq.valid), 64'd1);
    #1;
    reset = 1'b1;
    oresp = '{ready: 1'b1, last: 1'b1, data: BUS_DATA};
    #1;
    chk("rstmid_valid", 64'(oreq.valid), 64'd0);
    chk("rstmid_data_ok", 64'(iresp.data_ok), 64'd0);
    step();
    step();
    oresp = '0;
    reset = 1'b0;
    #1 chk("rstmid_idle", 64'(oreq.valid), 64'd0);
    step();
    chk("rstmid_regrant", 64'(oreq.valid), 64'd1);
    chk("rstmid_addr", oreq.addr, 64'h8000_0000);
    oresp = '{ready: 1'b1, last: 1'b1, data: BUS_DATA};
    #1;
    chk("rstmid_data_ok2", 64'(iresp.data_ok), 64'd1);
    chk("rstmid_data", 64'(iresp.data), 64'h5566_7788);
    step();
    ireq.valid = 1'b0;
    oresp      = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
    $finish;
  end

endmodule
